id_ex_stage: RTL
================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 reset  in  1  synchronous, active-high; sampled on rising edge of clk.
REQ-003 en_E  in  1  1 = load D-stage bundle; 0 = hold current contents.
REQ-004 clr_E  in  1  1 = replace contents with bubble on next edge (load-use stall or branch kill).
REQ-005 pc_D  in  32  PC of D-stage instruction.
REQ-006 rs_D, rt_D  in  5 each  source register numbers.
REQ-007 rs_val_D, rt_val_D  in  32 each  GRF read data.
REQ-008 imm_D  in  32  already-extended immediate.
REQ-009 alu_ctr_D  in  3  ALU op: 0 zero, 1 add, 2 sub, 3 or, 4 pass B.
REQ-010 alu_src_D  in  1  1 = B operand is imm, 0 = B operand is rt.
REQ-011 reg_wr_D, mem_wr_D, mem_to_reg_D  in  1 each  write-back / store / load flags.
REQ-012 wr_addr_D  in  5  destination register.
REQ-013 reg_wr_M, wr_addr_M[4:0], fwd_data_M[31:0]  in  M-stage forwarding source.
REQ-014 reg_wr_W, wr_addr_W[4:0], fwd_data_W[31:0]  in  W-stage forwarding source.
REQ-015 a_E, b_E  out  32 each  ALU operands.
REQ-016 alu_ctr_E  out  3  registered ALU op.
REQ-017 st_data_E  out  32  forwarded rt value for stores.
REQ-018 pc_E, pc8_E  out  32 each  registered PC and PC+8.
REQ-019 reg_wr_E, mem_wr_E, mem_to_reg_E  out  1 each; wr_addr_E out 5; rs_E, rt_E out 5 each (to hazard unit).
REQ-020 valid_E  out  1  1 = real instruction, 0 = bubble.

Function
REQ-021 Edge priority: reset > clr_E > en_E==0 (hold) > load.
REQ-022 Load: every D-stage input captured into its E-stage register; valid_E <= 1.
REQ-023 Bubble (clr_E or reset): all registers 0; valid_E 0; reg_wr_E, mem_wr_E 0, so bubble has no side effects.
REQ-024 clr_E together with en_E==0: bubble inserted (clear wins).
REQ-025 Hold: all registers unchanged, including valid_E.
REQ-026 Forwarded rs value: fwd_data_M if reg_wr_M and wr_addr_M==rs_E and rs_E!=0; else fwd_data_W if reg_wr_W and wr_addr_W==rs_E and rs_E!=0; else registered rs_val.
REQ-027 Forwarded rt value: same rule as REQ-026 with rt_E; M beats W on dual match.
REQ-028 Register 0 never forwarded; rs_E==0 yields registered value (0 from GRF).
REQ-029 a_E = forwarded rs; st_data_E = forwarded rt; b_E = alu_src_E ? imm_E : forwarded rt.
REQ-030 Forwarding mux purely combinational from registered fields plus M/W inputs; zero added latency.
REQ-031 pc8_E = pc_E + 32'd8, modulo 2^32 (0xFFFFFFFC -> 0x00000004).
REQ-032 D-to-E latency exactly one cycle when en_E=1, clr_E=0.
REQ-033 Forwarding applied even when valid_E=0; outputs harmless since bubble fields are 0.

Reset
REQ-034 With reset=1 at an edge, all registered outputs 0 and valid_E 0 after that edge, regardless of en_E/clr_E.
REQ-035 Reset mid-hold discards held instruction; first edge after reset deasserts loads normally.
REQ-036 No asynchronous path from reset to any output.

Configuration
REQ-037 Macro ID_EX_FWD_EN: when defined, REQ-026..REQ-028 forwarding implemented.
REQ-038 Without ID_EX_FWD_EN: forwarded rs/rt equal registered rs_val/rt_val; M/W inputs ignored; hazard unit stalls for all RAW hazards.

Verification
REQ-039 reset=1 one edge, en_E=1, pc_D=0x3000 -> all outputs 0, valid_E 0; next edge with reset=0 -> pc_E 0x3000, pc8_E 0x3008, valid_E 1.
REQ-040 rs_E=8, rs_val 5; reg_wr_M=1, wr_addr_M=8, data 0x11; reg_wr_W=1, wr_addr_W=8, data 0x22 -> a_E 0x11; drop M -> a_E 0x22; drop W -> a_E 5.
REQ-041 rt_E=0, reg_wr_M=1, wr_addr_M=0, data 0xFFFF -> st_data_E 0 (no forward); alu_src=1, imm 0x1234 -> b_E 0x1234.
REQ-042 Load add (alu_ctr 1), then en_E=0 for 3 edges with new D inputs -> E fields unchanged; then clr_E=1 with en_E=0 -> bubble, reg_wr_E 0, valid_E 0.
REQ-043 pc_D=0xFFFFFFFC -> pc8_E 0x00000004.
REQ-044 Build without ID_EX_FWD_EN, repeat REQ-040 stimulus -> a_E 5 throughout.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with optional M/W-stage operand forwarding.
// Define ID_EX_FWD_EN to enable forwarding; otherwise operands come straight from the GRF read data.
module id_ex_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        en_E,
  input  logic        clr_E,
  input  logic [31:0] pc_D,
  input  logic [4:0]  rs_D,
  input  logic [4:0]  rt_D,
  input  logic [31:0] rs_val_D,
  input  logic [31:0] rt_val_D,
  input  logic [31:0] imm_D,
  input  logic [2:0]  alu_ctr_D,
  input  logic        alu_src_D,
  input  logic        reg_wr_D,
  input  logic        mem_wr_D,
  input  logic        mem_to_reg_D,
  input  logic [4:0]  wr_addr_D,
  input  logic        reg_wr_M,
  input  logic [4:0]  wr_addr_M,
  input  logic [31:0] fwd_data_M,
  input  logic        reg_wr_W,
  input  logic [4:0]  wr_addr_W,
  input  logic [31:0] fwd_data_W,
  output logic [31:0] a_E,
  output logic [31:0] b_E,
  output logic [2:0]  alu_ctr_E,
  output logic [31:0] st_data_E,
  output logic [31:0] pc_E,
  output logic [31:0] pc8_E,
  output logic        reg_wr_E,
  output logic        mem_wr_E,
  output logic        mem_to_reg_E,
  output logic [4:0]  wr_addr_E,
  output logic [4:0]  rs_E,
  output logic [4:0]  rt_E,
  output logic        valid_E
);

  logic [31:0] rs_val_E;
  logic [31:0] rt_val_E;
  logic [31:0] imm_E;
  logic        alu_src_E;
  logic [31:0] fwd_rs;
  logic [31:0] fwd_rt;

  // PC+8 is registered so that a bubble presents all-zero outputs.
  always_ff @(posedge clk) begin
    if (reset || clr_E) begin
      pc_E         <= '0;
      pc8_E        <= '0;
      rs_E         <= '0;
      rt_E         <= '0;
      rs_val_E     <= '0;
      rt_val_E     <= '0;
      imm_E        <= '0;
      alu_ctr_E    <= '0;
      alu_src_E    <= 1'b0;
      reg_wr_E     <= 1'b0;
      mem_wr_E     <= 1'b0;
      mem_to_reg_E <= 1'b0;
      wr_addr_E    <= '0;
      valid_E      <= 1'b0;
    end else if (en_E) begin
      pc_E         <= pc_D;
      pc8_E        <= pc_D + 32'd8;
      rs_E         <= rs_D;
      rt_E         <= rt_D;
      rs_val_E     <= rs_val_D;
      rt_val_E     <= rt_val_D;
      imm_E        <= imm_D;
      alu_ctr_E    <= alu_ctr_D;
      alu_src_E    <= alu_src_D;
      reg_wr_E     <= reg_wr_D;
      mem_wr_E     <= mem_wr_D;
      mem_to_reg_E <= mem_to_reg_D;
      wr_addr_E    <= wr_addr_D;
      valid_E      <= 1'b1;
    end
  end

`ifdef ID_EX_FWD_EN
  // M is the younger producer, so it wins over W; register 0 is never forwarded.
  always_comb begin
    fwd_rs = rs_val_E;
    if (reg_wr_M && (wr_addr_M == rs_E) && (rs_E != 5'd0))
      fwd_rs = fwd_data_M;
    else if (reg_wr_W && (wr_addr_W == rs_E) && (rs_E != 5'd0))
      fwd_rs = fwd_data_W;
  end

  always_comb begin
    fwd_rt = rt_val_E;
    if (reg_wr_M && (wr_addr_M == rt_E) && (rt_E != 5'd0))
      fwd_rt = fwd_data_M;
    else if (reg_wr_W && (wr_addr_W == rt_E) && (rt_E != 5'd0))
      fwd_rt = fwd_data_W;
  end
`else
  logic unused_fwd;

  assign fwd_rs     = rs_val_E;
  assign fwd_rt     = rt_val_E;
  assign unused_fwd = ^{reg_wr_M, wr_addr_M, fwd_data_M, reg_wr_W, wr_addr_W, fwd_data_W};
`endif

  assign a_E       = fwd_rs;
  assign st_data_E = fwd_rt;
  assign b_E       = alu_src_E ? imm_E : fwd_rt;

endmodule
